// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and width helper for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } seq_mult_state_t;

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// rtl/seq_mult_dp.sv - shift-and-add datapath: operand magnitudes, accumulator, sign fix-up
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int N = 8,
  localparam int PW = prod_width(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          calc,
  input  logic          acc,
  input  logic          sign,
  input  logic          signed_mode,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          b_lsb,
  output logic          b_next_zero,
  output logic [PW-1:0] p_out
);

  logic [PW-1:0] a_reg;
  logic [N-1:0]  b_reg;
  logic [PW-1:0] p_reg;
  logic          neg;

  // Negation taken as unsigned N bits, so the most negative value maps onto 2^(N-1).
  function automatic logic [N-1:0] mag(input logic [N-1:0] v, input logic sm);
    return (sm && v[N-1]) ? -v : v;
  endfunction

  assign b_lsb       = b_reg[0];
  assign b_next_zero = ~|b_reg[N-1:1];

  always_ff @(posedge clk) begin
    if (clr) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
      neg   <= 1'b0;
      p_out <= '0;
    end else if (load) begin
      a_reg <= {{N{1'b0}}, mag(a_in, signed_mode)};
      b_reg <= mag(b_in, signed_mode);
      p_reg <= '0;
      neg   <= signed_mode & (a_in[N-1] ^ b_in[N-1]);
    end else if (calc) begin
      p_reg <= p_reg + (acc ? a_reg : '0);
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
    end else if (sign) begin
      p_out <= neg ? -p_reg : p_reg;
    end
  end

endmodule

// File: rtl/seq_mult_core.sv
// rtl/seq_mult_core.sv - start/done multiplier top with control FSM driving the datapath
module seq_mult_core
  import seq_mult_pkg::*;
#(
  parameter int N = 8,
  localparam int PW = prod_width(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] p_out
);

  seq_mult_state_t state, state_n;
  logic load, calc, sign;
  logic b_lsb, b_next_zero;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    calc    = 1'b0;
    sign    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        state_n = CALC;
      end
      CALC: begin
        calc = 1'b1;
        if (b_next_zero) state_n = SIGN;
      end
      SIGN: begin
        sign    = 1'b1;
        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode the state register only; nothing from start/a_in/b_in reaches them combinationally.
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  seq_mult_dp #(.N(N)) u_dp (
    .clk         (clk),
    .clr         (clr),
    .load        (load),
    .calc        (calc),
    .acc         (calc & b_lsb),
    .sign        (sign),
    .signed_mode (signed_mode),
    .a_in        (a_in),
    .b_in        (b_in),
    .b_lsb       (b_lsb),
    .b_next_zero (b_next_zero),
    .p_out       (p_out)
  );

endmodule
